gemm_axil_cmd_master: RTL and testbench



---
 rtl/gemm_axil_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_gemm_axil_cmd_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_axil_cmd_master.sv
// rtl/gemm_axil_cmd_master.sv - command/response stream to single-beat AXI4-Lite initiator (optional poll: GEMM_AXIL_POLL_EN)
module gemm_axil_cmd_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int POLL_MAX   = 1024,
    parameter int POLL_GAP   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    input  logic [31:0]           cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_GAP, S_RSP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_BADCMD = 2'b10;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

`ifdef GEMM_AXIL_POLL_EN
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 2);

    logic [31:0]             mask_q, mask_d;
    logic [ATT_W-1:0]        attempt_q, attempt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    poll_match;

    assign poll_match  = ((M_AXI_RDATA & mask_q) == (wdata_q & mask_q));
    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_mask;
    logic unused_cfg;

    // Without polling, the mask and poll tuning have no consumer.
    assign unused_mask = ^cmd_mask;
    assign unused_cfg  = (POLL_MAX < 1) || (POLL_GAP < 0);
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;

    // Next-state and registered-output decode; VALIDs only change at the edge.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef GEMM_AXIL_POLL_EN
        mask_d        = mask_q;
        attempt_d     = attempt_q;
        gap_d         = gap_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
`ifdef GEMM_AXIL_POLL_EN
                    mask_d        = cmd_mask;
                    attempt_d     = ATT_W'(1);
                    rsp_timeout_d = 1'b0;
`endif
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d   = S_WR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end
                        OP_READ, OP_POLL: begin
                            state_d   = S_RD_ADDR;
                            arvalid_d = 1'b1;
                        end
                        default: begin
                            // Reserved op: answer locally, never touch the bus.
                            state_d     = S_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_resp_d  = RESP_BADCMD;
                            rsp_rdata_d = 32'h0;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = 32'h0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
`ifdef GEMM_AXIL_POLL_EN
                    if (op_q == OP_POLL && M_AXI_RRESP == RESP_OKAY && !poll_match) begin
                        if (attempt_q == ATT_W'(POLL_MAX)) begin
                            rsp_timeout_d = 1'b1;
                            rsp_valid_d   = 1'b1;
                            state_d       = S_RSP;
                        end else begin
                            attempt_d = attempt_q + ATT_W'(1);
                            if (POLL_GAP == 0) begin
                                arvalid_d = 1'b1;
                                state_d   = S_RD_ADDR;
                            end else begin
                                gap_d   = GAP_W'(POLL_GAP);
                                state_d = S_POLL_GAP;
                            end
                        end
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RSP;
                    end
`else
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
`endif
                end
            end
`ifdef GEMM_AXIL_POLL_EN
            S_POLL_GAP: begin
                // Counts down POLL_GAP idle cycles before the next read attempt.
                if (gap_q <= GAP_W'(1)) begin
                    arvalid_d = 1'b1;
                    state_d   = S_RD_ADDR;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_resp_q  <= 2'b00;
`ifdef GEMM_AXIL_POLL_EN
            mask_q        <= 32'h0;
            attempt_q     <= ATT_W'(1);
            gap_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef GEMM_AXIL_POLL_EN
            mask_q        <= mask_d;
            attempt_q     <= attempt_d;
            gap_q         <= gap_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_gemm_axil_cmd_master.sv
// tb/tb_gemm_axil_cmd_master.sv - directed self-checking bench for gemm_axil_cmd_master
module tb_gemm_axil_cmd_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic [31:0] cmd_mask = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'h0;

    always #5 clk = ~clk;

    gemm_axil_cmd_master #(.ADDR_WIDTH(16), .POLL_MAX(4), .POLL_GAP(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // slave behaviour knobs
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    bit          b_hold = 1'b0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] rdq [0:7];
    int          rd_base = 0;

    // bus observation
    int          cyc = 0, aw_count = 0, w_count = 0, ar_count = 0;
    int          ar_cyc [0:31];
    logic [15:0] aw_addr_seen = 16'h0, ar_addr_seen = 16'h0;
    logic [31:0] w_data_seen = 32'h0;
    logic [3:0]  w_strb_seen = 4'h0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            aw_count = aw_count + 1;
            aw_addr_seen = M_AXI_AWADDR;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
            w_count = w_count + 1;
            w_data_seen = M_AXI_WDATA;
            w_strb_seen = M_AXI_WSTRB;
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            if (ar_count < 32) ar_cyc[ar_count] = cyc;
            ar_count = ar_count + 1;
            ar_addr_seen = M_AXI_ARADDR;
        end
    end

    always @(negedge clk) begin
        if (M_AXI_AWVALID) begin
            if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
            else begin M_AXI_AWREADY = 1'b0; aw_wait = aw_wait + 1; end
        end else begin
            M_AXI_AWREADY = 1'b0; aw_wait = 0;
        end
        if (M_AXI_WVALID) begin
            if (w_wait >= w_delay) M_AXI_WREADY = 1'b1;
            else begin M_AXI_WREADY = 1'b0; w_wait = w_wait + 1; end
        end else begin
            M_AXI_WREADY = 1'b0; w_wait = 0;
        end
        M_AXI_BVALID  = M_AXI_BREADY && !b_hold;
        M_AXI_BRESP   = b_resp;
        M_AXI_ARREADY = M_AXI_ARVALID;
        M_AXI_RVALID  = M_AXI_RREADY;
        M_AXI_RRESP   = r_resp;
        if (ar_count - rd_base >= 1 && ar_count - rd_base <= 8) M_AXI_RDATA = rdq[ar_count - rd_base - 1];
        else M_AXI_RDATA = 32'h0;
    end

    // Drives one command; lat counts negedges from acceptance until rsp_valid.
    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] mk,
                         output int lat, output logic awv1, output logic arv1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_mask = mk;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        awv1 = M_AXI_AWVALID;
        arv1 = M_AXI_ARVALID;
        while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
            n_bad++; $display("FAIL reset_handshakes: got %b want 00000",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin
            n_bad++; $display("FAIL reset_rsp_flags: got %b want 0000", {rsp_valid, rsp_timeout, rsp_resp}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 68'h0) begin
            n_bad++; $display("FAIL reset_payload: got %h want 0", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}); end
    endtask

    task automatic test_write_delayed;
        int lat; logic awv1, arv1; int aw0, w0;
        aw_delay = 3; w_delay = 0; b_resp = 2'b00;
        aw0 = aw_count; w0 = w_count;
        issue(2'b00, 16'h0040, 32'h0000_1234, 4'hF, 32'h0, lat, awv1, arv1);
        n_cmp++; if (awv1 !== 1'b1) begin n_bad++; $display("FAIL wr_awvalid_cycle1: got %b want 1", awv1); end
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wr_delayed_latency: got %0d want 6", lat); end
        n_cmp++; if (rsp_resp !== 2'b00) begin n_bad++; $display("FAIL wr_resp: got %b want 00", rsp_resp); end
        n_cmp++; if (aw_addr_seen !== 16'h0040) begin n_bad++; $display("FAIL wr_awaddr: got %h want 0040", aw_addr_seen); end
        n_cmp++; if ({w_data_seen, w_strb_seen} !== {32'h0000_1234, 4'hF}) begin
            n_bad++; $display("FAIL wr_wbeat: got %h/%h want 00001234/f", w_data_seen, w_strb_seen); end
        n_cmp++; if (M_AXI_AWPROT !== 3'b000) begin n_bad++; $display("FAIL awprot: got %b want 000", M_AXI_AWPROT); end
        finish_rsp();
        repeat (3) @(negedge clk);
        n_cmp++; if (aw_count - aw0 !== 1 || w_count - w0 !== 1) begin
            n_bad++; $display("FAIL wr_beat_count: got aw=%0d w=%0d want 1/1", aw_count - aw0, w_count - w0); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_back_idle: got %b want 1", cmd_ready); end
        aw_delay = 0;
    endtask

    task automatic test_write_error;
        int lat; logic awv1, arv1;
        b_resp = 2'b10;
        issue(2'b00, 16'h0044, 32'hCAFE_0001, 4'h3, 32'h0, lat, awv1, arv1);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_min_latency: got %0d want 3", lat); end
        n_cmp++; if (rsp_resp !== 2'b10) begin n_bad++; $display("FAIL wr_slverr: got %b want 10", rsp_resp); end
        n_cmp++; if (w_strb_seen !== 4'h3) begin n_bad++; $display("FAIL wr_strb: got %h want 3", w_strb_seen); end
        finish_rsp();
        b_resp = 2'b00;
    endtask

    task automatic test_read;
        int lat; logic awv1, arv1; int ar0;
        rd_base = ar_count; ar0 = ar_count; rdq[0] = 32'hDEAD_BEEF; r_resp = 2'b00;
        issue(2'b01, 16'h0080, 32'h0, 4'h0, 32'h0, lat, awv1, arv1);
        n_cmp++; if (arv1 !== 1'b1) begin n_bad++; $display("FAIL rd_arvalid_cycle1: got %b want 1", arv1); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
        n_cmp++; if (ar_addr_seen !== 16'h0080 || ar_count - ar0 !== 1) begin
            n_bad++; $display("FAIL rd_ar_beat: got addr=%h n=%0d want 0080/1", ar_addr_seen, ar_count - ar0); end
        // Payload must stay stable while the response is withheld.
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rd_hold: got %b/%h want 1/deadbeef", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_poll_match;
        int lat; logic awv1, arv1; int ar0;
        rd_base = ar_count; ar0 = ar_count;
        rdq[0] = 32'h0; rdq[1] = 32'h0; rdq[2] = 32'h1; rdq[3] = 32'h1;
        issue(2'b10, 16'h0010, 32'h1, 4'h0, 32'h1, lat, awv1, arv1);
`ifdef GEMM_AXIL_POLL_EN
        n_cmp++; if (ar_count - ar0 !== 3) begin n_bad++; $display("FAIL poll_reads: got %0d want 3", ar_count - ar0); end
        n_cmp++; if (ar_cyc[ar0 + 1] - ar_cyc[ar0] < 9 || ar_cyc[ar0 + 2] - ar_cyc[ar0 + 1] < 9) begin
            n_bad++; $display("FAIL poll_spacing: got %0d,%0d want >=9",
                ar_cyc[ar0 + 1] - ar_cyc[ar0], ar_cyc[ar0 + 2] - ar_cyc[ar0 + 1]); end
        n_cmp++; if (rsp_rdata !== 32'h1) begin n_bad++; $display("FAIL poll_rdata: got %h want 1", rsp_rdata); end
`else
        rdq[0] = rdq[0];
        n_cmp++; if (ar_count - ar0 !== 1) begin n_bad++; $display("FAIL poll_as_read: got %0d want 1", ar_count - ar0); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL poll_as_read_data: got %h want 0", rsp_rdata); end
`endif
        n_cmp++; if (rsp_timeout !== 1'b0 || rsp_resp !== 2'b00) begin
            n_bad++; $display("FAIL poll_match_flags: got %b/%b want 0/00", rsp_timeout, rsp_resp); end
        finish_rsp();
    endtask

    task automatic test_poll_timeout;
        int lat; logic awv1, arv1; int ar0;
        rd_base = ar_count; ar0 = ar_count;
        for (int i = 0; i < 8; i++) rdq[i] = 32'h0;
        issue(2'b10, 16'h0014, 32'h1, 4'h0, 32'h1, lat, awv1, arv1);
`ifdef GEMM_AXIL_POLL_EN
        n_cmp++; if (ar_count - ar0 !== 4) begin n_bad++; $display("FAIL timeout_reads: got %0d want 4", ar_count - ar0); end
        n_cmp++; if (rsp_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b want 1", rsp_timeout); end
`else
        n_cmp++; if (ar_count - ar0 !== 1) begin n_bad++; $display("FAIL timeout_reads: got %0d want 1", ar_count - ar0); end
        n_cmp++; if (rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_flag: got %b want 0", rsp_timeout); end
`endif
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL timeout_rsp: got %b want 1", rsp_valid); end
        finish_rsp();
    endtask

    task automatic test_reserved;
        int lat; logic awv1, arv1; int aw0, w0, ar0;
        aw0 = aw_count; w0 = w_count; ar0 = ar_count;
        issue(2'b11, 16'h0020, 32'h5555_AAAA, 4'hF, 32'h0, lat, awv1, arv1);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rsv_latency: got %0d want 1", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL rsv_hold%0d: got v=%b resp=%b rdy=%b busy=%b want 1/10/0/1",
                    i, rsp_valid, rsp_resp, cmd_ready, busy); end
            @(negedge clk);
        end
        n_cmp++; if (aw_count != aw0 || w_count != w0 || ar_count != ar0) begin
            n_bad++; $display("FAIL rsv_no_bus: got aw=%0d w=%0d ar=%0d want 0/0/0",
                aw_count - aw0, w_count - w0, ar_count - ar0); end
        finish_rsp();
        n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rsv_release: got rdy=%b v=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid;
        int n;
        b_hold = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h0048; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!M_AXI_BREADY && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (M_AXI_BREADY !== 1'b1) begin n_bad++; $display("FAIL mid_reach_wr_resp: got %b want 1", M_AXI_BREADY); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid} !== 6'b0) begin
            n_bad++; $display("FAIL mid_reset_drop: got %b want 000000",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", cmd_ready); end
        reset = 1'b0;
        b_hold = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_response: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        int lat; logic awv1, arv1;
        rd_base = ar_count; rdq[0] = 32'h0BAD_F00D;
        issue(2'b01, 16'h0084, 32'h0, 4'h0, 32'h0, lat, awv1, arv1);
        n_cmp++; if (rsp_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_rdata: got %h want 0badf00d", rsp_rdata); end
        finish_rsp();
        issue(2'b00, 16'h004C, 32'hA5A5_5A5A, 4'hC, 32'h0, lat, awv1, arv1);
        n_cmp++; if (lat !== 3 || rsp_resp !== 2'b00) begin
            n_bad++; $display("FAIL b2b_write: got lat=%0d resp=%b want 3/00", lat, rsp_resp); end
        n_cmp++; if ({aw_addr_seen, w_data_seen, w_strb_seen} !== {16'h004C, 32'hA5A5_5A5A, 4'hC}) begin
            n_bad++; $display("FAIL b2b_wpayload: got %h/%h/%h want 004c/a5a55a5a/c", aw_addr_seen, w_data_seen, w_strb_seen); end
        finish_rsp();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rdq[i] = 32'h0;
        test_reset();
        test_write_delayed();
        test_write_error();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
